// File: rtl/hist_pkg.sv
// Shared types and constants for the TDC histogram frame controller.
// Optional build macro used by hist_frame_ctrl: HIST_FRAME_TIMEOUT_EN.
package hist_pkg;

    localparam int TDC_W = 15;
    localparam int BIN_W = 4;
    localparam int CNT_W = 10;

    // WAIT_MAX watchdog terminal value and the bin reported when it fires
    localparam logic [15:0]      TIMEOUT_MAX = 16'hFFFF;
    localparam logic [BIN_W-1:0] TIMEOUT_BIN = 4'hF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_MAX = 2'd2,
        ACK      = 2'd3
    } state_t;

    // Extract the bin field that starts at bit lsb of a TDC code
    function automatic logic [BIN_W-1:0] tdc_bin(input logic [TDC_W-1:0] code,
                                                 input int lsb);
        return BIN_W'(code >> lsb);
    endfunction

endpackage

// File: rtl/hist_sfifo.sv
// Synchronous FIFO with full/empty flags. Push is also accepted while full
// when a pop happens on the same cycle, leaving the occupancy unchanged.
module hist_sfifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hist_frame_ctrl.sv
// Histogram frame controller: buffers TDC codes, streams FRAME_LEN bin
// indices to count_max, then collects the frame peak through a
// valid/ready handshake. Define HIST_FRAME_TIMEOUT_EN to add a 16-bit
// watchdog on WAIT_MAX that forces completion with frame_max = 0xF.
module hist_frame_ctrl
    import hist_pkg::*;
#(
    parameter int FRAME_LEN  = 50,
    parameter int FIFO_DEPTH = 8,
    parameter int BIN_LSB    = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [TDC_W-1:0] tdc_data,
    input  logic             tdc_valid,
    output logic             tdc_ready,
    output logic [BIN_W-1:0] Q_4bit,
    output logic             count_max_en,
    input  logic [BIN_W-1:0] max_4bit,
    input  logic             count_max_Ovalid,
    output logic             count_max_Oready,
    output logic [BIN_W-1:0] frame_max,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ready_en;
    logic             fifo_full;
    logic             fifo_empty;
    logic [TDC_W-1:0] fifo_dout;
    logic             push;
    logic             pop;

`ifdef HIST_FRAME_TIMEOUT_EN
    logic [15:0]      to_cnt;
    logic             to_hit;
`endif

    // ready_en keeps tdc_ready low through reset and for the release cycle
    assign tdc_ready = ready_en & ~fifo_full;
    assign push      = tdc_valid & tdc_ready;
    assign pop       = (state == STREAM) & ~fifo_empty;

    hist_sfifo #(
        .WIDTH (TDC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (tdc_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Upstream ready enables on the first clock after reset release
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ready_en <= 1'b0;
        else
            ready_en <= 1'b1;
    end

    // Frame FSM with registered outputs; strobes default low every cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= IDLE;
            cnt              <= '0;
            Q_4bit           <= '0;
            count_max_en     <= 1'b0;
            count_max_Oready <= 1'b0;
            frame_max        <= '0;
            frame_done       <= 1'b0;
`ifdef HIST_FRAME_TIMEOUT_EN
            to_cnt           <= '0;
            to_hit           <= 1'b0;
`endif
        end else begin
            count_max_en     <= 1'b0;
            count_max_Oready <= 1'b0;
            frame_done       <= 1'b0;
            case (state)
                IDLE: begin
`ifdef HIST_FRAME_TIMEOUT_EN
                    to_cnt <= '0;
                    to_hit <= 1'b0;
`endif
                    if (!fifo_empty) begin
                        state <= STREAM;
                        cnt   <= '0;
                    end
                end
                STREAM: begin
                    // Q_4bit holds and the counter stalls when nothing pops
                    if (pop) begin
                        Q_4bit       <= tdc_bin(fifo_dout, BIN_LSB);
                        count_max_en <= 1'b1;
                        cnt          <= cnt + 1'b1;
                        if (cnt == LAST_IDX)
                            state <= WAIT_MAX;
                    end
                end
                WAIT_MAX: begin
                    if (count_max_Ovalid) begin
                        state            <= ACK;
                        count_max_Oready <= 1'b1;
                    end
`ifdef HIST_FRAME_TIMEOUT_EN
                    else if (to_cnt == TIMEOUT_MAX - 16'd1) begin
                        state            <= ACK;
                        count_max_Oready <= 1'b1;
                        to_hit           <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end
                ACK: begin
`ifdef HIST_FRAME_TIMEOUT_EN
                    frame_max <= to_hit ? TIMEOUT_BIN : max_4bit;
`else
                    frame_max <= max_4bit;
`endif
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hist_frame_ctrl.sv
// Directed bench for hist_frame_ctrl with a bin scoreboard.
module tb_hist_frame_ctrl;

    localparam int FRAME_LEN  = 50;
    localparam int FIFO_DEPTH = 8;
    localparam int BIN_LSB    = 3;

    logic        clk;
    logic        rstn;
    logic [14:0] tdc_data;
    logic        tdc_valid;
    logic        tdc_ready;
    logic [3:0]  Q_4bit;
    logic        count_max_en;
    logic [3:0]  max_4bit;
    logic        count_max_Ovalid;
    logic        count_max_Oready;
    logic [3:0]  frame_max;
    logic        frame_done;

    int          vectors;
    int          miscompares;
    logic [3:0]  exp_q[$];
    logic [3:0]  last_q;
    logic [3:0]  mon_e;
    int          en_total;
    int          done_total;
    int          ordy_total;
    bit          mon_on;

    hist_frame_ctrl #(
        .FRAME_LEN  (FRAME_LEN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BIN_LSB    (BIN_LSB)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .tdc_data         (tdc_data),
        .tdc_valid        (tdc_valid),
        .tdc_ready        (tdc_ready),
        .Q_4bit           (Q_4bit),
        .count_max_en     (count_max_en),
        .max_4bit         (max_4bit),
        .count_max_Ovalid (count_max_Ovalid),
        .count_max_Oready (count_max_Oready),
        .frame_max        (frame_max),
        .frame_done       (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bench actions happen 1 time unit after the falling edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [14:0] mk_code(input int k);
        logic [14:0] c;
        c = 15'($urandom);
        c[BIN_LSB +: 4] = 4'(k);
        return c;
    endfunction

    // Offer one code for a single cycle; scoreboard it only if accepted
    task automatic push_code(input logic [14:0] c, output bit acc);
        tdc_valid = 1'b1;
        tdc_data  = c;
        acc       = tdc_ready;
        if (acc)
            exp_q.push_back(c[BIN_LSB +: 4]);
        tick();
        tdc_valid = 1'b0;
    endtask

    // Scoreboard consumer: every enabled bin pops an expectation,
    // otherwise Q_4bit must hold the last streamed bin
    always @(negedge clk) begin
        if (rstn && mon_on) begin
            if (count_max_en) begin
                en_total++;
                if (exp_q.size() == 0) begin
                    chk("en_without_code", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("q_bin", {28'd0, Q_4bit}, {28'd0, mon_e});
                    last_q = mon_e;
                end
            end else begin
                chk("q_hold", {28'd0, Q_4bit}, {28'd0, last_q});
            end
            if (frame_done)       done_total++;
            if (count_max_Oready) ordy_total++;
        end
    end

    task automatic handshake(input logic [3:0] mx, input string tag);
        int n;
        int d0;
        int r0;
        d0 = done_total;
        r0 = ordy_total;
        count_max_Ovalid = 1'b1;
        max_4bit         = mx;
        n = 0;
        while (!count_max_Oready && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_oready"}, {31'd0, count_max_Oready}, 32'd1);
        count_max_Ovalid = 1'b0;
        tick();
        chk({tag, "_oready_drop"}, {31'd0, count_max_Oready}, 32'd0);
        chk({tag, "_done"}, {31'd0, frame_done}, 32'd1);
        chk({tag, "_frame_max"}, {28'd0, frame_max}, {28'd0, mx});
        max_4bit = 4'd0;
        tick();
        chk({tag, "_done_pulse"}, {31'd0, frame_done}, 32'd0);
        chk({tag, "_done_count"}, done_total - d0, 32'd1);
        chk({tag, "_oready_count"}, ordy_total - r0, 32'd1);
        chk({tag, "_frame_max_kept"}, {28'd0, frame_max}, {28'd0, mx});
    endtask

    // Wait until en_total reaches target, bounded
    task automatic wait_en(input int target, input int bound);
        int n;
        n = 0;
        while (en_total < target && n < bound) begin
            tick();
            n++;
        end
    endtask

    initial begin
        bit acc;
        int k;
        int tries;
        int e0;
        int acc_cnt;
        int n;

        vectors = 0; miscompares = 0;
        en_total = 0; done_total = 0; ordy_total = 0;
        mon_on = 1'b0; last_q = 4'd0;
        rstn = 1'b0; tdc_data = '0; tdc_valid = 1'b0;
        max_4bit = '0; count_max_Ovalid = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_ready", {31'd0, tdc_ready}, 32'd0);
        chk("rst_q", {28'd0, Q_4bit}, 32'd0);
        chk("rst_en", {31'd0, count_max_en}, 32'd0);
        chk("rst_oready", {31'd0, count_max_Oready}, 32'd0);
        chk("rst_frame_max", {28'd0, frame_max}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        rstn = 1'b1;
        chk("rel_ready_before_edge", {31'd0, tdc_ready}, 32'd0);
        tick();
        chk("rel_ready_after_edge", {31'd0, tdc_ready}, 32'd1);
        mon_on = 1'b1;

        // Ovalid outside WAIT_MAX is ignored
        count_max_Ovalid = 1'b1; max_4bit = 4'd5;
        repeat (3) begin
            tick();
            chk("idle_ovalid_oready", {31'd0, count_max_Oready}, 32'd0);
        end
        count_max_Ovalid = 1'b0; max_4bit = 4'd0;
        tick();
        chk("idle_ovalid_done", done_total, 32'd0);
        chk("idle_ovalid_frame_max", {28'd0, frame_max}, 32'd0);

        // Nominal frame: 50 codes back-to-back, bins k mod 16
        e0 = en_total;
        k = 0; tries = 0;
        while (k < FRAME_LEN && tries < 200) begin
            push_code(mk_code(k), acc);
            if (acc) k++;
            tries++;
        end
        chk("nom_pushed", k, FRAME_LEN);
        wait_en(e0 + FRAME_LEN, 100);
        chk("nom_en_count", en_total - e0, FRAME_LEN);
        chk("nom_sb_empty", exp_q.size(), 32'd0);

        // Backpressure while waiting for the peak: only FIFO_DEPTH fit
        acc_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            push_code(mk_code(i + 3), acc);
            if (acc) acc_cnt++;
        end
        chk("bp_accepts", acc_cnt, FIFO_DEPTH);
        chk("bp_ready_low", {31'd0, tdc_ready}, 32'd0);
        repeat (8) tick();
        chk("wait_no_extra_en", en_total - e0, FRAME_LEN);
        chk("wait_no_done", done_total, 32'd0);

        // Peak handshake 20 cycles after the frame
        handshake(4'd7, "hs1");

        // Second frame: buffered codes first, then 1-of-3 gaps
        e0 = en_total;
        wait_en(e0 + FIFO_DEPTH, 50);
        chk("f2_buffered_pops", en_total - e0, FIFO_DEPTH);
        chk("f2_ready_back", {31'd0, tdc_ready}, 32'd1);
        for (int g = 0; g < FRAME_LEN - FIFO_DEPTH; g++) begin
            logic [14:0] c;
            c = mk_code(g * 5);
            push_code(c, acc);
            chk("gap_accept", {31'd0, acc}, 32'd1);
            chk("gap_lat1_en", {31'd0, count_max_en}, 32'd0);
            tick();
            chk("gap_lat2_en", {31'd0, count_max_en}, 32'd1);
            chk("gap_lat2_q", {28'd0, Q_4bit}, {28'd0, c[BIN_LSB +: 4]});
            tick();
        end
        repeat (5) tick();
        chk("f2_en_count", en_total - e0, FRAME_LEN);
        chk("f2_sb_empty", exp_q.size(), 32'd0);
        handshake(4'hA, "hs2");

        // Reset in the middle of a streaming frame
        e0 = en_total;
        for (int i = 0; i < 6; i++) push_code(mk_code(i + 9), acc);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, tdc_ready}, 32'd0);
        chk("mid_rst_q", {28'd0, Q_4bit}, 32'd0);
        chk("mid_rst_en", {31'd0, count_max_en}, 32'd0);
        chk("mid_rst_oready", {31'd0, count_max_Oready}, 32'd0);
        chk("mid_rst_frame_max", {28'd0, frame_max}, 32'd0);
        chk("mid_rst_done", {31'd0, frame_done}, 32'd0);
        exp_q.delete();
        last_q = 4'd0;
        repeat (2) tick();
        e0 = en_total;
        rstn = 1'b1;
        tick();
        chk("mid_rel_ready", {31'd0, tdc_ready}, 32'd1);
        repeat (6) tick();
        chk("mid_rel_fifo_empty", en_total - e0, 32'd0);

`ifdef HIST_FRAME_TIMEOUT_EN
        // Watchdog: no Ovalid, forced completion with error bin
        e0 = en_total;
        k = 0; tries = 0;
        while (k < FRAME_LEN && tries < 200) begin
            push_code(mk_code(k + 1), acc);
            if (acc) k++;
            tries++;
        end
        wait_en(e0 + FRAME_LEN, 100);
        chk("to_en_count", en_total - e0, FRAME_LEN);
        n = 0;
        while (!frame_done && n < 70000) begin
            tick();
            n++;
        end
        chk("to_done", {31'd0, frame_done}, 32'd1);
        chk("to_cycles", n, 32'd65536);
        chk("to_frame_max", {28'd0, frame_max}, 32'hF);
`else
        n = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hist_frame_ctrl.md
HIST_FRAME_CTRL -- requirements
Module: hist_frame_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 50: samples per histogram frame, legal 1..1023.
REQ-002 Parameter FIFO_DEPTH, default 8: input buffer entries, power of two, 2..64.
REQ-003 Parameter BIN_LSB, default 3: LSB of the 4-bit bin field within a 15-bit TDC code, legal 0..11.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 tdc_data  input  15  TDC code from upstream.
REQ-007 tdc_valid  input  1  tdc_data valid.
REQ-008 tdc_ready  output  1  buffer can accept a code.
REQ-009 Q_4bit  output  4  bin index driven to count_max.
REQ-010 count_max_en  output  1  count_max enable; high while the frame streams.
REQ-011 max_4bit  input  4  peak bin from count_max.
REQ-012 count_max_Ovalid  input  1  count_max result valid.
REQ-013 count_max_Oready  output  1  result accept strobe to count_max.
REQ-014 frame_max  output  4  registered peak bin of the last completed frame.
REQ-015 frame_done  output  1  one-cycle pulse when frame_max updates.

Function
REQ-016 An upstream transfer SHALL occur on a cycle with tdc_valid=1 and tdc_ready=1, with tdc_ready=1 exactly when the FIFO is not full.
REQ-017 The FSM SHALL have states IDLE, STREAM, WAIT_MAX and ACK.
REQ-018 IDLE->STREAM SHALL occur when the FIFO is non-empty; the frame sample counter clears to 0.
REQ-019 In STREAM, each cycle with the FIFO non-empty SHALL pop one entry, drive Q_4bit=tdc_data[BIN_LSB+3:BIN_LSB] registered one cycle later, assert count_max_en on that same cycle, and increment the counter.
REQ-020 In STREAM with the FIFO empty, count_max_en SHALL be 0, Q_4bit SHALL hold its value and the counter SHALL hold.
REQ-021 When the counter reaches FRAME_LEN, the FSM SHALL move to WAIT_MAX, and no further pops SHALL occur until the next IDLE.
REQ-022 Bin latency from tdc_data accept to Q_4bit SHALL be 2 cycles with an empty FIFO.
REQ-023 In WAIT_MAX, count_max_Ovalid=1 SHALL move to ACK; count_max_Oready SHALL be 1 only in ACK, for exactly one cycle.
REQ-024 In ACK, frame_max SHALL load max_4bit, frame_done SHALL pulse, and the FSM SHALL return to IDLE.
REQ-025 Simultaneous push and pop SHALL be legal at any occupancy, including full, where the FIFO count is unchanged.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 A push attempt while the FIFO is full SHALL be ignored, because tdc_ready=0.
REQ-028 count_max_Ovalid outside WAIT_MAX SHALL be ignored.

Reset
REQ-029 On reset assertion, without waiting for clk, the following SHALL apply: FSM=IDLE, FIFO empty, counter=0, tdc_ready=0, Q_4bit=0, count_max_en=0, count_max_Oready=0, frame_max=0, frame_done=0.
REQ-030 tdc_ready SHALL rise on the first clk edge after rstn deasserts.
REQ-031 Reset mid-frame SHALL discard the partial frame and all buffered codes.

Configuration
REQ-032 With HIST_FRAME_TIMEOUT_EN defined, a 16-bit counter SHALL run in WAIT_MAX, and reaching 0xFFFF without Ovalid SHALL force ACK with frame_max=0xF as an error marker.
REQ-033 Without HIST_FRAME_TIMEOUT_EN, WAIT_MAX SHALL wait indefinitely, and the timeout counter SHALL not exist.

Structure
REQ-034 Package hist_pkg SHALL hold the FSM state enum, TDC_W=15, BIN_W=4 and the timeout constant.
REQ-035 The FIFO SHALL be the sub-module hist_sfifo, a synchronous FIFO parameterised by width and depth with full/empty flags.

Verification
REQ-036 Reset: rstn low mid-STREAM -> all outputs 0 immediately, and the FIFO is empty after release.
REQ-037 Nominal frame: FRAME_LEN=50, 50 codes with bits[6:3]=k mod 16 pushed back-to-back -> exactly 50 count_max_en cycles, Q_4bit follows the sequence, then WAIT_MAX.
REQ-038 Handshake: model asserts Ovalid with max_4bit=7, 20 cycles after the frame -> Oready one cycle, frame_max=7, and one frame_done pulse.
REQ-039 Backpressure: FIFO_DEPTH=8, 12 codes pushed while in WAIT_MAX -> tdc_ready low after 8 accepts, and exactly 8 codes are popped in the next frame.
REQ-040 Gaps: tdc_valid 1-of-3 cycles -> count_max_en gaps match, Q_4bit holds through the gaps, and the frame still totals 50.
REQ-041 Timeout (HIST_FRAME_TIMEOUT_EN defined): no Ovalid -> ACK after 65535 WAIT_MAX cycles, and frame_max=0xF.
